bp_btb_bht_param: RTL and testbench

//  Parametrised branch predictor for the IF stage: direct-mapped BTB with full tag, plus a per-entry
//  CTR_BITS saturating counter (BHT). Lookups are registered: the prediction arrives 1 cycle after

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_sat_ctr.sv | 21 ++
 rtl/bp_btb_bht_param.sv | 156 +++++++++++++++
 tb/tb_bp_btb_bht_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: address width, saturating-counter
// encoding helpers and the BTB entry layout used by predictor blocks.
package bp_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned CTR_MAX_W = 8;

   // Fields are sized for the widest supported configuration; users slice down.
   typedef struct packed {
      logic                 valid;
      logic [ADDR_W-1:0]    tag;
      logic [ADDR_W-1:0]    target;
      logic [CTR_MAX_W-1:0] ctr;
   } bp_entry_t;

   function automatic logic [31:0] ctr_max(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

   function automatic logic [31:0] ctr_wt(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

   function automatic logic [31:0] ctr_wn(input int unsigned bits);
      return ctr_wt(bits) - 32'd1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] cur, input int unsigned bits);
      return (cur >= ctr_max(bits)) ? cur : cur + 32'd1;
   endfunction

   function automatic logic [31:0] sat_dec(input logic [31:0] cur, input int unsigned bits);
      return (cur == 32'd0) ? cur : cur - 32'd1;
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next-state of one saturating branch-history counter.
module bp_sat_ctr
   import bp_pkg::*;
#(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] cur,
   input  logic                taken,
   output logic [CTR_BITS-1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (taken) begin
         nxt = CTR_BITS'(sat_inc(32'(cur), CTR_BITS));
      end else begin
         nxt = CTR_BITS'(sat_dec(32'(cur), CTR_BITS));
      end
   end

endmodule

// File: rtl/bp_btb_bht_param.sv
// Direct-mapped BTB with per-entry saturating taken counters; registered
// one-cycle lookup, EX-stage write-back port and saturating perf counters.
module bp_btb_bht_param
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES     = 64,
   parameter int unsigned CTR_BITS    = 2,
   parameter int unsigned ALLOC_TAKEN = 1,
   parameter int unsigned PERF_W      = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              predict_en,
   input  logic [31:0]       pc,
   output logic              pred_valid,
   output logic              pred_jump,
   output logic [31:0]       pred_pc,
   input  logic              upd_en,
   input  logic [31:0]       upd_addr,
   input  logic              upd_jumpinst,
   input  logic              upd_jump,
   input  logic              upd_predfail,
   input  logic [31:0]       upd_target,
   output logic [PERF_W-1:0] perf_lookup,
   output logic [PERF_W-1:0] perf_hit,
   output logic [PERF_W-1:0] perf_miss
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_BITS-1:0] WT = CTR_BITS'(ctr_wt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] WN = CTR_BITS'(ctr_wn(CTR_BITS));

   function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v, input logic ev);
      return (ev && (v != '1)) ? v + 1'b1 : v;
   endfunction

   logic                valid_q  [ENTRIES];
   logic                valid_d  [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [TAG_W-1:0]    tag_d    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [31:0]         target_d [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
   logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

   logic                pred_valid_q, pred_valid_d;
   logic                pred_jump_q, pred_jump_d;
   logic [31:0]         pred_pc_q, pred_pc_d;
   logic [PERF_W-1:0]   perf_lookup_q, perf_lookup_d;
   logic [PERF_W-1:0]   perf_hit_q, perf_hit_d;
   logic [PERF_W-1:0]   perf_miss_q, perf_miss_d;

   logic [IDX_W-1:0]    rd_idx, wr_idx;
   logic [TAG_W-1:0]    rd_tag, wr_tag;
   logic                rd_hit, rd_jump, wr_hit, upd_act;
   logic [CTR_BITS-1:0] ctr_nxt;
   logic                unused_addr_lsb;

   assign unused_addr_lsb = ^{pc[1:0], upd_addr[1:0]};

   assign rd_idx  = pc[IDX_W+1:2];
   assign rd_tag  = pc[31:IDX_W+2];
   assign wr_idx  = upd_addr[IDX_W+1:2];
   assign wr_tag  = upd_addr[31:IDX_W+2];
   assign upd_act = upd_en & upd_jumpinst;

   // Lookup reads registered table state, so a same-cycle update is not visible.
   always_comb begin
      rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      rd_jump = rd_hit && ctr_q[rd_idx][CTR_BITS-1];
      wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
   end

   bp_sat_ctr #(
      .CTR_BITS (CTR_BITS)
   ) u_sat_ctr (
      .cur   (ctr_q[wr_idx]),
      .taken (upd_jump),
      .nxt   (ctr_nxt)
   );

   always_comb begin
      pred_valid_d = predict_en;
      pred_jump_d  = pred_jump_q;
      pred_pc_d    = pred_pc_q;
      if (predict_en) begin
         pred_jump_d = rd_jump;
         pred_pc_d   = rd_jump ? target_q[rd_idx] : pc + 32'd4;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_act) begin
         if (wr_hit) begin
            ctr_d[wr_idx] = ctr_nxt;
            if (upd_jump) begin
               target_d[wr_idx] = upd_target;
            end
         end else if (upd_jump || (ALLOC_TAKEN == 0)) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = upd_target;
            ctr_d[wr_idx]    = upd_jump ? WT : WN;
         end
      end
   end

   always_comb begin
      perf_lookup_d = perf_inc(perf_lookup_q, predict_en);
      perf_hit_d    = perf_inc(perf_hit_q, predict_en & rd_hit);
      perf_miss_d   = perf_inc(perf_miss_q, upd_act & upd_predfail);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q       <= '{default: 1'b0};
         ctr_q         <= '{default: WT};
         pred_valid_q  <= 1'b0;
         pred_jump_q   <= 1'b0;
         pred_pc_q     <= '0;
         perf_lookup_q <= '0;
         perf_hit_q    <= '0;
         perf_miss_q   <= '0;
      end else begin
         valid_q       <= valid_d;
         ctr_q         <= ctr_d;
         pred_valid_q  <= pred_valid_d;
         pred_jump_q   <= pred_jump_d;
         pred_pc_q     <= pred_pc_d;
         perf_lookup_q <= perf_lookup_d;
         perf_hit_q    <= perf_hit_d;
         perf_miss_q   <= perf_miss_d;
      end
   end

   // Tags and targets are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (resetn) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

   assign pred_valid  = pred_valid_q;
   assign pred_jump   = pred_jump_q;
   assign pred_pc     = pred_pc_q;
   assign perf_lookup = perf_lookup_q;
   assign perf_hit    = perf_hit_q;
   assign perf_miss   = perf_miss_q;

endmodule

// File: tb/tb_bp_btb_bht_param.sv
// Scoreboard bench for bp_btb_bht_param (ENTRIES=64, CTR_BITS=2, ALLOC_TAKEN=1).
module tb_bp_btb_bht_param;

   logic        clk = 1'b0;
   logic        resetn;
   logic        predict_en;
   logic [31:0] pc;
   logic        pred_valid, pred_jump;
   logic [31:0] pred_pc;
   logic        upd_en, upd_jumpinst, upd_jump, upd_predfail;
   logic [31:0] upd_addr, upd_target;
   logic [31:0] perf_lookup, perf_hit, perf_miss;

   typedef struct {
      logic        jump;
      logic [31:0] npc;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   m_lookup = 0, m_hit = 0, m_miss = 0;

   bp_btb_bht_param #(
      .ENTRIES(64), .CTR_BITS(2), .ALLOC_TAKEN(1), .PERF_W(32)
   ) dut (
      .clk(clk), .resetn(resetn), .predict_en(predict_en), .pc(pc),
      .pred_valid(pred_valid), .pred_jump(pred_jump), .pred_pc(pred_pc),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_jumpinst(upd_jumpinst),
      .upd_jump(upd_jump), .upd_predfail(upd_predfail), .upd_target(upd_target),
      .perf_lookup(perf_lookup), .perf_hit(perf_hit), .perf_miss(perf_miss)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every presented prediction is matched against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (pred_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pred: got pc 0x%08h expected no prediction", pred_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_jump"}, {31'd0, pred_jump}, {31'd0, e.jump});
            check({e.name, "_pc"}, pred_pc, e.npc);
         end
      end
   end

   task automatic clear_inputs();
      predict_en = 1'b0; pc = '0;
      upd_en = 1'b0; upd_addr = '0; upd_jumpinst = 1'b0;
      upd_jump = 1'b0; upd_predfail = 1'b0; upd_target = '0;
   endtask

   task automatic set_predict(input logic [31:0] a, input logic ej, input logic [31:0] epc,
                              input logic ehit, input string name);
      exp_t e;
      predict_en = 1'b1; pc = a;
      e.jump = ej; e.npc = epc; e.name = name;
      exp_q.push_back(e);
      m_lookup++;
      if (ehit) m_hit++;
   endtask

   task automatic set_update(input logic [31:0] a, input logic j, input logic [31:0] tgt,
                             input logic pf);
      upd_en = 1'b1; upd_jumpinst = 1'b1; upd_addr = a;
      upd_jump = j; upd_target = tgt; upd_predfail = pf;
      if (pf) m_miss++;
   endtask

   task automatic tick();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic predict(input logic [31:0] a, input logic ej, input logic [31:0] epc,
                          input logic ehit, input string name);
      set_predict(a, ej, epc, ehit, name);
      tick();
   endtask

   task automatic update(input logic [31:0] a, input logic j, input logic [31:0] tgt,
                         input logic pf);
      set_update(a, j, tgt, pf);
      tick();
   endtask

   task automatic check_perf(input string name);
      check({name, "_lookup"}, perf_lookup, m_lookup);
      check({name, "_hit"}, perf_hit, m_hit);
      check({name, "_miss"}, perf_miss, m_miss);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      check("rst_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_jump", {31'd0, pred_jump}, 32'd0);
      check("rst_pc", pred_pc, 32'd0);
      check_perf("rst");

      // 1: cold lookup
      predict(32'h100, 1'b0, 32'h104, 1'b0, "t1_cold");
      check_perf("t1");

      // 2: allocate taken, then train down 2->1->0
      update(32'h100, 1'b1, 32'h200, 1'b0);
      predict(32'h100, 1'b1, 32'h200, 1'b1, "t2_taken");
      update(32'h100, 1'b0, 32'h0, 1'b1);
      update(32'h100, 1'b0, 32'h0, 1'b0);
      predict(32'h100, 1'b0, 32'h104, 1'b1, "t2_nt");
      check_perf("t2");

      // 3: alias on index 0
      predict(32'h200, 1'b0, 32'h204, 1'b0, "t3_alias");
      update(32'h200, 1'b1, 32'h300, 1'b1);
      predict(32'h100, 1'b0, 32'h104, 1'b0, "t3_evicted");
      predict(32'h200, 1'b1, 32'h300, 1'b1, "t3_new");
      check_perf("t3");

      // 4: saturation at max, then decrement twice
      for (int i = 0; i < 5; i++) update(32'h40, 1'b1, 32'h500, 1'b0);
      update(32'h40, 1'b0, 32'h0, 1'b0);
      predict(32'h40, 1'b1, 32'h500, 1'b1, "t4_sat");
      update(32'h40, 1'b0, 32'h0, 1'b0);
      predict(32'h40, 1'b0, 32'h44, 1'b1, "t4_dec");
      update(32'h40, 1'b1, 32'h600, 1'b0);
      predict(32'h40, 1'b1, 32'h600, 1'b1, "t4_retarget");
      update(32'h60, 1'b0, 32'h700, 1'b0);
      predict(32'h60, 1'b0, 32'h64, 1'b0, "t4_noalloc");
      check_perf("t4");

      // 5: same-cycle predict and allocate, read-before-write
      set_predict(32'h80, 1'b0, 32'h84, 1'b0, "t5_same");
      set_update(32'h80, 1'b1, 32'h880, 1'b0);
      tick();
      predict(32'h80, 1'b1, 32'h880, 1'b1, "t5_next");
      check_perf("t5");

      // 6: reset between back-to-back hits
      predict(32'h80, 1'b1, 32'h880, 1'b1, "t6_hit0");
      predict(32'h80, 1'b1, 32'h880, 1'b1, "t6_hit1");
      resetn = 1'b0;
      predict_en = 1'b1; pc = 32'h80;
      tick();
      resetn = 1'b1;
      m_lookup = 0; m_hit = 0; m_miss = 0;
      check("t6_rst_valid", {31'd0, pred_valid}, 32'd0);
      check("t6_rst_jump", {31'd0, pred_jump}, 32'd0);
      check("t6_rst_pc", pred_pc, 32'd0);
      check_perf("t6_rst");
      predict(32'h80, 1'b0, 32'h84, 1'b0, "t6_cleared");
      predict(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, "t6_wrap");
      tick();
      check("t6_hold_valid", {31'd0, pred_valid}, 32'd0);
      check("t6_hold_pc", pred_pc, 32'h0);
      check_perf("t6");

      tick();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
